// File: rtl/register_status_table_if.sv
// ---------------------------------------------------------------------------
// register_status_table_if
// Bundles the issue, common-data-bus, flush and operand/busy signals of the
// register status table. Two issue slots (k) and two CDB ports (j: 0=ADD,
// 1=MUL) are carried as packed [1:0] arrays.
//   master : issue/CDB/flush producer, consumes operands and busy_count
//   slave  : the register status table itself
// ---------------------------------------------------------------------------
interface register_status_table_if #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3,
    parameter int IDX_W  = 5
);
    logic [1:0]                   iss_valid;
    logic [1:0][IDX_W-1:0]        iss_src_a;
    logic [1:0][IDX_W-1:0]        iss_src_b;
    logic [1:0][IDX_W-1:0]        iss_dst;
    logic [1:0][TAG_W-1:0]        iss_tag;
    logic [1:0]                   cdb_valid;
    logic [1:0][TAG_W-1:0]        cdb_tag;
    logic [1:0][DATA_W-1:0]       cdb_data;
    logic                         flush;
    logic [1:0][DATA_W-1:0]       opa_val;
    logic [1:0][DATA_W-1:0]       opb_val;
    logic [1:0][TAG_W-1:0]        opa_tag;
    logic [1:0][TAG_W-1:0]        opb_tag;
    logic [1:0]                   opa_rdy;
    logic [1:0]                   opb_rdy;
    logic [IDX_W:0]               busy_count;

    modport master (
        output iss_valid, iss_src_a, iss_src_b, iss_dst, iss_tag,
        output cdb_valid, cdb_tag, cdb_data, flush,
        input  opa_val, opb_val, opa_tag, opb_tag, opa_rdy, opb_rdy, busy_count
    );

    modport slave (
        input  iss_valid, iss_src_a, iss_src_b, iss_dst, iss_tag,
        input  cdb_valid, cdb_tag, cdb_data, flush,
        output opa_val, opb_val, opa_tag, opb_tag, opa_rdy, opb_rdy, busy_count
    );
endinterface

// File: rtl/register_status_table.sv
// ---------------------------------------------------------------------------
// register_status_table
// Tomasulo-style register status table: per architectural register a ready
// bit, the tag of the reservation station that will produce it, and the last
// committed value. Two issue slots read operands and rename destinations each
// cycle; two CDB ports complete pending renames; flush drops all renames.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (entry i -> rdy=1, tag=0, value=i)
//   bus    : register_status_table_if.slave
//            iss_* (2 slots), cdb_* (2 ports), flush in;
//            opa_*/opb_* (registered, held until next issue on that slot)
//            and busy_count out
//
// Optional feature: define RST_CDB_BYPASS_EN to forward a same-cycle CDB
// broadcast into a not-ready operand lookup instead of returning its tag.
// ---------------------------------------------------------------------------
module register_status_table #(
    parameter int NUM_REGS = 18,
    parameter int DATA_W   = 8,
    parameter int TAG_W    = 3,
    parameter int IDX_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    register_status_table_if.slave  bus
);

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);

    logic [NUM_REGS-1:0]             r_rdy;
    logic [NUM_REGS-1:0][TAG_W-1:0]  r_tag;
    logic [NUM_REGS-1:0][DATA_W-1:0] r_val;
    logic [IDX_W:0]                  r_busy;
    opnd_t [1:0][1:0]                r_op;      // [slot][0=a,1=b]

    logic [NUM_REGS-1:0]             w_nxt_rdy;
    logic [NUM_REGS-1:0][TAG_W-1:0]  w_nxt_tag;
    logic [NUM_REGS-1:0][DATA_W-1:0] w_nxt_val;
    logic [IDX_W:0]                  w_busy;
    logic [1:0][1:0][IDX_W-1:0]      w_src;
    opnd_t [1:0][1:0]                w_op;

    assign w_src[0][0] = bus.iss_src_a[0];
    assign w_src[0][1] = bus.iss_src_b[0];
    assign w_src[1][0] = bus.iss_src_a[1];
    assign w_src[1][1] = bus.iss_src_b[1];

    // Operand lookup against pre-update table state.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            for (int o = 0; o < 2; o++) begin
                // Out-of-range indices read as a ready zero.
                w_op[k][o]     = '0;
                w_op[k][o].rdy = 1'b1;
                if (32'(w_src[k][o]) < NUM_REGS) begin
                    w_op[k][o].rdy = r_rdy[w_src[k][o]];
                    w_op[k][o].tag = r_tag[w_src[k][o]];
                    w_op[k][o].val = r_val[w_src[k][o]];
                    // Slot 1 consuming slot 0's destination in the same group
                    // must wait on slot 0's tag, not the stale table entry.
                    if (k == 1 && bus.iss_valid[0] &&
                        bus.iss_dst[0] == w_src[k][o]) begin
                        w_op[k][o].rdy = 1'b0;
                        w_op[k][o].tag = bus.iss_tag[0];
                    end
                end
                if (bus.flush)
                    w_op[k][o].rdy = 1'b1;
`ifdef RST_CDB_BYPASS_EN
                // Port 0 has priority, mirroring the table update.
                if (!w_op[k][o].rdy) begin
                    if (bus.cdb_valid[0] && bus.cdb_tag[0] == w_op[k][o].tag) begin
                        w_op[k][o].rdy = 1'b1;
                        w_op[k][o].val = bus.cdb_data[0];
                    end else if (bus.cdb_valid[1] &&
                                 bus.cdb_tag[1] == w_op[k][o].tag) begin
                        w_op[k][o].rdy = 1'b1;
                        w_op[k][o].val = bus.cdb_data[1];
                    end
                end
`endif
            end
        end
    end

    // Table next state. Priority per entry: flush > rename (slot 1 > slot 0)
    // > CDB (port 0 > port 1). A renamed entry keeps its old value.
    always_comb begin
        w_nxt_rdy = r_rdy;
        w_nxt_tag = r_tag;
        w_nxt_val = r_val;
        w_busy    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.flush) begin
                w_nxt_rdy[i] = 1'b1;
            end else if (bus.iss_valid[1] && 32'(bus.iss_dst[1]) == i) begin
                w_nxt_rdy[i] = 1'b0;
                w_nxt_tag[i] = bus.iss_tag[1];
            end else if (bus.iss_valid[0] && 32'(bus.iss_dst[0]) == i) begin
                w_nxt_rdy[i] = 1'b0;
                w_nxt_tag[i] = bus.iss_tag[0];
            end else if (!r_rdy[i] && bus.cdb_valid[0] &&
                         bus.cdb_tag[0] == r_tag[i]) begin
                w_nxt_rdy[i] = 1'b1;
                w_nxt_val[i] = bus.cdb_data[0];
            end else if (!r_rdy[i] && bus.cdb_valid[1] &&
                         bus.cdb_tag[1] == r_tag[i]) begin
                w_nxt_rdy[i] = 1'b1;
                w_nxt_val[i] = bus.cdb_data[1];
            end
            if (!w_nxt_rdy[i])
                w_busy = w_busy + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rdy[i] <= 1'b1;
                r_tag[i] <= '0;
                r_val[i] <= DATA_W'(i);
            end
            r_busy <= '0;
            r_op   <= '0;
        end else begin
            r_rdy  <= w_nxt_rdy;
            r_tag  <= w_nxt_tag;
            r_val  <= w_nxt_val;
            r_busy <= w_busy;
            for (int k = 0; k < 2; k++)
                if (bus.iss_valid[k])
                    r_op[k] <= w_op[k];
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_out
        assign bus.opa_val[k] = r_op[k][0].val;
        assign bus.opa_tag[k] = r_op[k][0].tag;
        assign bus.opa_rdy[k] = r_op[k][0].rdy;
        assign bus.opb_val[k] = r_op[k][1].val;
        assign bus.opb_tag[k] = r_op[k][1].tag;
        assign bus.opb_rdy[k] = r_op[k][1].rdy;
    end

    assign bus.busy_count = r_busy;

endmodule

// File: tb/tb_register_status_table.sv
module tb_register_status_table;
    localparam int NUM_REGS = 18;
    localparam int DATA_W   = 8;
    localparam int TAG_W    = 3;
    localparam int IDX_W    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    register_status_table_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .IDX_W(IDX_W)) bus();

    register_status_table #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .TAG_W(TAG_W), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: architectural view of the table plus expected outputs.
    bit                m_rdy [NUM_REGS];
    logic [TAG_W-1:0]  m_tag [NUM_REGS];
    logic [DATA_W-1:0] m_val [NUM_REGS];
    bit                e_ar [2], e_br [2];
    logic [TAG_W-1:0]  e_at [2], e_bt [2];
    logic [DATA_W-1:0] e_av [2], e_bv [2];
    logic [IDX_W:0]    e_busy;

    task automatic lookup(input int k, input int s, output bit r,
                          output logic [TAG_W-1:0] t, output logic [DATA_W-1:0] v);
        r = 1'b1; t = '0; v = '0;
        if (s < NUM_REGS) begin
            r = m_rdy[s]; t = m_tag[s]; v = m_val[s];
            if (k == 1 && bus.iss_valid[0] && int'(bus.iss_dst[0]) == s) begin
                r = 1'b0; t = bus.iss_tag[0];
            end
        end
        if (bus.flush) r = 1'b1;
`ifdef RST_CDB_BYPASS_EN
        if (!r) begin
            if (bus.cdb_valid[0] && bus.cdb_tag[0] == t) begin r = 1'b1; v = bus.cdb_data[0]; end
            else if (bus.cdb_valid[1] && bus.cdb_tag[1] == t) begin r = 1'b1; v = bus.cdb_data[1]; end
        end
`endif
    endtask

    // Advance model with the currently driven inputs, then clock the DUT.
    task automatic cycle();
        bit renamed [NUM_REGS];
        int n;
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                m_rdy[i] = 1'b1; m_tag[i] = '0; m_val[i] = DATA_W'(i);
            end
            for (int k = 0; k < 2; k++) begin
                e_ar[k] = 0; e_br[k] = 0; e_at[k] = '0; e_bt[k] = '0; e_av[k] = '0; e_bv[k] = '0;
            end
            e_busy = '0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (bus.iss_valid[k]) begin
                    lookup(k, int'(bus.iss_src_a[k]), e_ar[k], e_at[k], e_av[k]);
                    lookup(k, int'(bus.iss_src_b[k]), e_br[k], e_bt[k], e_bv[k]);
                end
            if (bus.flush) begin
                for (int i = 0; i < NUM_REGS; i++) m_rdy[i] = 1'b1;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) renamed[i] = 0;
                for (int k = 0; k < 2; k++)
                    if (bus.iss_valid[k] && int'(bus.iss_dst[k]) < NUM_REGS)
                        renamed[bus.iss_dst[k]] = 1;
                for (int i = 0; i < NUM_REGS; i++)
                    if (!renamed[i] && !m_rdy[i]) begin
                        if (bus.cdb_valid[0] && bus.cdb_tag[0] == m_tag[i]) begin
                            m_rdy[i] = 1'b1; m_val[i] = bus.cdb_data[0];
                        end else if (bus.cdb_valid[1] && bus.cdb_tag[1] == m_tag[i]) begin
                            m_rdy[i] = 1'b1; m_val[i] = bus.cdb_data[1];
                        end
                    end
                for (int k = 0; k < 2; k++)
                    if (bus.iss_valid[k] && int'(bus.iss_dst[k]) < NUM_REGS) begin
                        m_rdy[bus.iss_dst[k]] = 1'b0; m_tag[bus.iss_dst[k]] = bus.iss_tag[k];
                    end
            end
            n = 0;
            for (int i = 0; i < NUM_REGS; i++) if (!m_rdy[i]) n++;
            e_busy = (IDX_W+1)'(n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iss_valid = '0; bus.iss_src_a = '0; bus.iss_src_b = '0;
        bus.iss_dst = '0; bus.iss_tag = '0;
        bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.flush = 1'b0;
    endtask

    task automatic iss(input int k, input int a, input int b, input int dst, input int tag);
        bus.iss_valid[k] = 1'b1;
        bus.iss_src_a[k] = IDX_W'(a);
        bus.iss_src_b[k] = IDX_W'(b);
        bus.iss_dst[k]   = IDX_W'(dst);
        bus.iss_tag[k]   = TAG_W'(tag);
    endtask

    task automatic cdb(input int j, input int tag, input int data);
        bus.cdb_valid[j] = 1'b1;
        bus.cdb_tag[j]   = TAG_W'(tag);
        bus.cdb_data[j]  = DATA_W'(data);
    endtask

    task automatic do_reset();
        idle(); rst_n = 1'b0; cycle(); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Reset must win over simultaneous issue, CDB and flush.
        rst_n = 1'b0;
        iss(0, 1, 2, 3, 4); iss(1, 5, 6, 7, 1); cdb(0, 0, 8'h99); bus.flush = 1'b1;
        cycle();
        checks++; if (bus.busy_count !== 0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", bus.busy_count); end
        checks++; if ({bus.opa_rdy, bus.opb_rdy} !== 4'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", {bus.opa_rdy, bus.opb_rdy}); end
        checks++; if ({bus.opa_val, bus.opb_val, bus.opa_tag, bus.opb_tag} !== '0) begin failures++; $display("FAIL reset_vals got=%h exp=0", {bus.opa_val, bus.opb_val}); end
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i += 2) begin
            idle(); iss(0, i, i + 1, 31, 0);
            cycle();
            checks++; if (bus.opa_val[0] !== DATA_W'(i) || bus.opa_rdy[0] !== 1'b1) begin failures++; $display("FAIL reset_entry%0d got=%0h/%b exp=%0h/1", i, bus.opa_val[0], bus.opa_rdy[0], i); end
            checks++; if (bus.opb_val[0] !== DATA_W'(i + 1) || bus.opb_rdy[0] !== 1'b1) begin failures++; $display("FAIL reset_entry%0d got=%0h/%b exp=%0h/1", i + 1, bus.opb_val[0], bus.opb_rdy[0], i + 1); end
        end
    endtask

    task automatic test_read();
        do_reset(); iss(0, 3, 5, 31, 0); cycle(); idle();
        checks++; if (bus.opa_val[0] !== 8'd3 || bus.opa_rdy[0] !== 1'b1) begin failures++; $display("FAIL read_a got=%0h/%b exp=3/1", bus.opa_val[0], bus.opa_rdy[0]); end
        checks++; if (bus.opb_val[0] !== 8'd5 || bus.opb_rdy[0] !== 1'b1) begin failures++; $display("FAIL read_b got=%0h/%b exp=5/1", bus.opb_val[0], bus.opb_rdy[0]); end
        checks++; if (bus.busy_count !== 0) begin failures++; $display("FAIL read_busy got=%0d exp=0", bus.busy_count); end
        // Outputs hold while no instruction issues.
        cycle();
        checks++; if (bus.opa_val[0] !== 8'd3) begin failures++; $display("FAIL read_hold got=%0h exp=3", bus.opa_val[0]); end
    endtask

    task automatic test_rename_cdb();
        do_reset(); iss(0, 0, 0, 4, 2); cycle(); idle();
        iss(0, 4, 0, 31, 0); cycle(); idle();
        checks++; if (bus.opa_rdy[0] !== 1'b0 || bus.opa_tag[0] !== 3'd2) begin failures++; $display("FAIL rename_op got=%b/%0d exp=0/2", bus.opa_rdy[0], bus.opa_tag[0]); end
        checks++; if (bus.busy_count !== 1) begin failures++; $display("FAIL rename_busy got=%0d exp=1", bus.busy_count); end
        cdb(0, 2, 8'h2A); cycle(); idle();
        checks++; if (bus.busy_count !== 0) begin failures++; $display("FAIL cdb_busy got=%0d exp=0", bus.busy_count); end
        iss(0, 4, 0, 31, 0); cycle(); idle();
        checks++; if (bus.opa_rdy[0] !== 1'b1 || bus.opa_val[0] !== 8'h2A) begin failures++; $display("FAIL cdb_value got=%b/%0h exp=1/2a", bus.opa_rdy[0], bus.opa_val[0]); end
    endtask

    task automatic test_intra_group();
        do_reset(); iss(0, 0, 0, 6, 1); iss(1, 6, 5, 31, 0); cycle(); idle();
        checks++; if (bus.opa_rdy[1] !== 1'b0 || bus.opa_tag[1] !== 3'd1) begin failures++; $display("FAIL intra_dep got=%b/%0d exp=0/1", bus.opa_rdy[1], bus.opa_tag[1]); end
        checks++; if (bus.opb_rdy[1] !== 1'b1 || bus.opb_val[1] !== 8'd5) begin failures++; $display("FAIL intra_indep got=%b/%0h exp=1/5", bus.opb_rdy[1], bus.opb_val[1]); end
        checks++; if (bus.busy_count !== 1) begin failures++; $display("FAIL intra_busy got=%0d exp=1", bus.busy_count); end
    endtask

    task automatic test_rename_wins();
        do_reset(); iss(0, 0, 0, 7, 3); cycle(); idle();
        iss(0, 0, 0, 7, 5); cdb(1, 3, 8'h55); cycle(); idle();
        checks++; if (bus.busy_count !== 1) begin failures++; $display("FAIL renwin_busy got=%0d exp=1", bus.busy_count); end
        iss(0, 7, 0, 31, 0); cycle(); idle();
        checks++; if (bus.opa_rdy[0] !== 1'b0 || bus.opa_tag[0] !== 3'd5) begin failures++; $display("FAIL renwin_entry got=%b/%0d exp=0/5", bus.opa_rdy[0], bus.opa_tag[0]); end
        // Same destination in both slots: slot 1 tag survives.
        iss(0, 0, 0, 8, 2); iss(1, 0, 0, 8, 6); cycle(); idle();
        iss(0, 8, 0, 31, 0); cycle(); idle();
        checks++; if (bus.opa_rdy[0] !== 1'b0 || bus.opa_tag[0] !== 3'd6) begin failures++; $display("FAIL samedst got=%b/%0d exp=0/6", bus.opa_rdy[0], bus.opa_tag[0]); end
    endtask

    task automatic test_bypass();
        do_reset(); iss(0, 0, 0, 9, 4); cycle(); idle();
        cdb(0, 4, 8'h11); iss(0, 9, 0, 31, 0); cycle(); idle();
`ifdef RST_CDB_BYPASS_EN
        checks++; if (bus.opa_rdy[0] !== 1'b1 || bus.opa_val[0] !== 8'h11) begin failures++; $display("FAIL bypass got=%b/%0h exp=1/11", bus.opa_rdy[0], bus.opa_val[0]); end
`else
        checks++; if (bus.opa_rdy[0] !== 1'b0 || bus.opa_tag[0] !== 3'd4) begin failures++; $display("FAIL nobypass got=%b/%0d exp=0/4", bus.opa_rdy[0], bus.opa_tag[0]); end
`endif
        checks++; if (bus.busy_count !== 0) begin failures++; $display("FAIL bypass_busy got=%0d exp=0", bus.busy_count); end
        iss(0, 9, 0, 31, 0); cycle(); idle();
        checks++; if (bus.opa_rdy[0] !== 1'b1 || bus.opa_val[0] !== 8'h11) begin failures++; $display("FAIL bypass_entry got=%b/%0h exp=1/11", bus.opa_rdy[0], bus.opa_val[0]); end
    endtask

    task automatic test_flush_reset();
        do_reset(); iss(0, 0, 0, 1, 1); iss(1, 0, 0, 2, 2); cycle(); idle();
        iss(0, 0, 0, 3, 3); cycle(); idle();
        checks++; if (bus.busy_count !== 3) begin failures++; $display("FAIL pre_flush_busy got=%0d exp=3", bus.busy_count); end
        // Flush overrides the rename of 10 and the CDB write to entry 1.
        bus.flush = 1'b1; iss(0, 1, 2, 10, 6); cdb(0, 1, 8'hFF); cycle(); idle();
        checks++; if (bus.busy_count !== 0) begin failures++; $display("FAIL flush_busy got=%0d exp=0", bus.busy_count); end
        checks++; if (bus.opa_rdy[0] !== 1'b1 || bus.opa_val[0] !== 8'd1) begin failures++; $display("FAIL flush_opa got=%b/%0h exp=1/1", bus.opa_rdy[0], bus.opa_val[0]); end
        iss(0, 3, 10, 31, 0); cycle(); idle();
        checks++; if (bus.opa_val[0] !== 8'd3 || bus.opb_val[0] !== 8'd10 || bus.opb_rdy[0] !== 1'b1) begin failures++; $display("FAIL flush_keep got=%0h/%0h exp=3/a", bus.opa_val[0], bus.opb_val[0]); end
        iss(0, 0, 0, 4, 7); cycle(); idle();
        cdb(1, 7, 8'hC3); cycle(); idle();
        iss(0, 4, 0, 31, 0); cycle(); idle();
        checks++; if (bus.opa_val[0] !== 8'hC3) begin failures++; $display("FAIL mul_cdb got=%0h exp=c3", bus.opa_val[0]); end
        iss(0, 0, 0, 5, 2); rst_n = 1'b0; cycle(); rst_n = 1'b1; idle();
        checks++; if (bus.opa_rdy[0] !== 1'b0 || bus.opa_val[0] !== 8'd0 || bus.busy_count !== 0) begin failures++; $display("FAIL midreset got=%b/%0h/%0d exp=0/0/0", bus.opa_rdy[0], bus.opa_val[0], bus.busy_count); end
        iss(0, 4, 5, 31, 0); cycle(); idle();
        checks++; if (bus.opa_val[0] !== 8'd4 || bus.opb_val[0] !== 8'd5 || bus.opb_rdy[0] !== 1'b1) begin failures++; $display("FAIL midreset_vals got=%0h/%0h exp=4/5", bus.opa_val[0], bus.opb_val[0]); end
    endtask

    task automatic test_out_of_range();
        do_reset(); iss(0, 20, 31, 25, 3); iss(1, 18, 2, 30, 1); cycle(); idle();
        checks++; if (bus.opa_rdy[0] !== 1'b1 || bus.opa_val[0] !== 8'd0 || bus.opb_val[0] !== 8'd0) begin failures++; $display("FAIL oor_read got=%b/%0h/%0h exp=1/0/0", bus.opa_rdy[0], bus.opa_val[0], bus.opb_val[0]); end
        checks++; if (bus.opa_rdy[1] !== 1'b1 || bus.opb_val[1] !== 8'd2) begin failures++; $display("FAIL oor_slot1 got=%b/%0h exp=1/2", bus.opa_rdy[1], bus.opb_val[1]); end
        checks++; if (bus.busy_count !== 0) begin failures++; $display("FAIL oor_write got=%0d exp=0", bus.busy_count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle();
            rst_n = ($urandom_range(0, 63) != 0);
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 3) != 0)
                    iss(k, $urandom_range(0, 31), $urandom_range(0, 31),
                        $urandom_range(0, 21), $urandom_range(0, 7));
            for (int j = 0; j < 2; j++)
                if ($urandom_range(0, 1) != 0) cdb(j, $urandom_range(0, 7), $urandom_range(0, 255));
            bus.flush = ($urandom_range(0, 15) == 0);
            cycle();
            checks++; if (bus.busy_count !== e_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%0d exp=%0d", c, bus.busy_count, e_busy); end
            for (int k = 0; k < 2; k++) begin
                checks++; if (bus.opa_rdy[k] !== e_ar[k]) begin failures++; $display("FAIL rnd_opa_rdy c=%0d k=%0d got=%b exp=%b", c, k, bus.opa_rdy[k], e_ar[k]); end
                checks++; if (bus.opb_rdy[k] !== e_br[k]) begin failures++; $display("FAIL rnd_opb_rdy c=%0d k=%0d got=%b exp=%b", c, k, bus.opb_rdy[k], e_br[k]); end
                checks++;
                if (e_ar[k] ? (bus.opa_val[k] !== e_av[k]) : (bus.opa_tag[k] !== e_at[k])) begin
                    failures++; $display("FAIL rnd_opa c=%0d k=%0d got=%0h/%0d exp=%0h/%0d", c, k, bus.opa_val[k], bus.opa_tag[k], e_av[k], e_at[k]);
                end
                checks++;
                if (e_br[k] ? (bus.opb_val[k] !== e_bv[k]) : (bus.opb_tag[k] !== e_bt[k])) begin
                    failures++; $display("FAIL rnd_opb c=%0d k=%0d got=%0h/%0d exp=%0h/%0d", c, k, bus.opb_val[k], bus.opb_tag[k], e_bv[k], e_bt[k]);
                end
            end
        end
        rst_n = 1'b1; idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_read();
        test_rename_cdb();
        test_intra_group();
        test_rename_wins();
        test_bypass();
        test_flush_reset();
        test_out_of_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
